// File: rtl/ll_detect_unit.sv
// Line-length event detector: onset confirmation, hysteresis release and
// post-event holdoff on the valid-qualified feature stream from ll_comp_unit.
module ll_detect_unit #(
    parameter int input_width    = 32,
    parameter int onset_count    = 4,
    parameter int offset_count   = 4,
    parameter int holdoff_cycles = 16,
    parameter int hyst           = 10,
    parameter int cnt_width      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic signed [input_width:0] din,
    input  logic                        din_valid,
    input  logic signed [input_width:0] thresh,
    output logic                        detect,
    output logic                        detect_pulse,
    output logic [cnt_width-1:0]        event_count,
    output logic                        busy
);

    localparam int CW      = input_width + 2;
    localparam int RUN_MAX = (onset_count > offset_count) ? onset_count : offset_count;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int HOLD_W  = (holdoff_cycles > 0) ? $clog2(holdoff_cycles + 1) : 1;

    localparam logic [RUN_W-1:0]    ONSET_N  = RUN_W'(onset_count);
    localparam logic [RUN_W-1:0]    OFFSET_N = RUN_W'(offset_count);
    localparam logic [HOLD_W-1:0]   HOLD_N   = HOLD_W'(holdoff_cycles);
    localparam logic signed [CW-1:0] HYST_X  = CW'(hyst);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MONITOR,
        S_CONFIRM,
        S_ALARM,
        S_HOLDOFF
    } state_t;

    state_t                state_q, state_d;
    logic [RUN_W-1:0]      run_q, run_d, run_inc;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic                  detect_q, detect_d;
    logic                  pulse_q, pulse_d;
    logic [cnt_width-1:0]  count_q, count_d;
    logic                  busy_q, busy_d;

    logic signed [CW-1:0]  din_x, thr_x, rel_x, rel_c;
    logic                  above, below;

    // Widened by one bit so thresh - hyst never wraps; negative samples and
    // a negative release level both clamp to zero.
    always_comb begin
        din_x = din[input_width] ? '0 : {din[input_width], din};
        thr_x = {thresh[input_width], thresh};
        rel_x = thr_x - HYST_X;
        rel_c = rel_x[CW-1] ? '0 : rel_x;
        above = din_x > thr_x;
        below = din_x < rel_c;
    end

    assign run_inc = run_q + RUN_W'(1);

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        hold_d   = hold_q;
        detect_d = detect_q;
        pulse_d  = 1'b0;
        count_d  = count_q;

        if (!en) begin
            state_d  = S_IDLE;
            run_d    = '0;
            hold_d   = '0;
            detect_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d  = S_MONITOR;
                    detect_d = 1'b0;
                end

                S_MONITOR: begin
                    if (din_valid && above) begin
                        if (onset_count == 1) begin
                            state_d  = S_ALARM;
                            run_d    = '0;
                            detect_d = 1'b1;
                            pulse_d  = 1'b1;
                            count_d  = (count_q == '1) ? count_q : count_q + 1'b1;
                        end else begin
                            state_d = S_CONFIRM;
                            run_d   = RUN_W'(1);
                        end
                    end
                end

                S_CONFIRM: begin
                    if (din_valid) begin
                        if (!above) begin
                            state_d = S_MONITOR;
                            run_d   = '0;
                        end else if (run_inc == ONSET_N) begin
                            state_d  = S_ALARM;
                            run_d    = '0;
                            detect_d = 1'b1;
                            pulse_d  = 1'b1;
                            count_d  = (count_q == '1) ? count_q : count_q + 1'b1;
                        end else begin
                            run_d = run_inc;
                        end
                    end
                end

                S_ALARM: begin
                    if (din_valid) begin
                        if (!below) begin
                            run_d = '0;
                        end else if (run_inc == OFFSET_N) begin
                            run_d    = '0;
                            detect_d = 1'b0;
                            hold_d   = HOLD_N;
                            state_d  = (holdoff_cycles == 0) ? S_MONITOR : S_HOLDOFF;
                        end else begin
                            run_d = run_inc;
                        end
                    end
                end

                S_HOLDOFF: begin
                    // Exits on the edge that consumes the last count, so the
                    // block spends exactly holdoff_cycles clocks here.
                    if (hold_q <= HOLD_W'(1)) begin
                        hold_d  = '0;
                        state_d = S_MONITOR;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end

                default: begin
                    state_d  = S_IDLE;
                    run_d    = '0;
                    hold_d   = '0;
                    detect_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == S_CONFIRM) || (state_d == S_ALARM) || (state_d == S_HOLDOFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            run_q    <= '0;
            hold_q   <= '0;
            detect_q <= 1'b0;
            pulse_q  <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            hold_q   <= hold_d;
            detect_q <= detect_d;
            pulse_q  <= pulse_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    assign detect       = detect_q;
    assign detect_pulse = pulse_q;
    assign event_count  = count_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_ll_detect_unit.sv
// Directed bench for ll_detect_unit; per-cycle expectations are queued as each
// step is driven and checked once the registered outputs settle.
module tb_ll_detect_unit;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [32:0] din;
    logic               din_valid;
    logic signed [32:0] thresh;
    logic               detect;
    logic               detect_pulse;
    logic [15:0]        event_count;
    logic               busy;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        logic        det;
        logic        pul;
        logic        bsy;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    ll_detect_unit #(
        .input_width   (32),
        .onset_count   (4),
        .offset_count  (4),
        .holdoff_cycles(16),
        .hyst          (10),
        .cnt_width     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .din         (din),
        .din_valid   (din_valid),
        .thresh      (thresh),
        .detect      (detect),
        .detect_pulse(detect_pulse),
        .event_count (event_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic signed [32:0] d,
                        input logic e_det, input logic e_pul, input logic e_bsy,
                        input logic [15:0] e_cnt, input string tag);
        exp_t e;
        exp_t g;
        din_valid = v;
        din       = d;
        e.det = e_det; e.pul = e_pul; e.bsy = e_bsy; e.cnt = e_cnt; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        chk({g.tag, ".detect"}, {31'd0, detect}, {31'd0, g.det});
        chk({g.tag, ".pulse"},  {31'd0, detect_pulse}, {31'd0, g.pul});
        chk({g.tag, ".busy"},   {31'd0, busy}, {31'd0, g.bsy});
        chk({g.tag, ".count"},  {16'd0, event_count}, {16'd0, g.cnt});
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; din_valid = 1'b1; din = 33'sd500; thresh = 33'sd100;

        // Reset held two cycles with a large valid sample present
        step(1, 500, 0, 0, 0, 0, "rst0");
        step(1, 500, 0, 0, 0, 0, "rst1");
        rst = 1'b0;
        step(1, 500, 0, 0, 0, 0, "post_rst");

        // Onset: four valid 150s above thresh=100
        step(0, 0, 0, 0, 0, 0, "mon_idle");
        for (int i = 1; i <= 4; i++)
            step(1, 150, i == 4, i == 4, 1, (i == 4) ? 16'd1 : 16'd0, $sformatf("onset%0d", i));
        step(0, 0, 1, 0, 1, 1, "onset_pulse_end");

        // Samples inside the hysteresis band keep detect high
        for (int i = 0; i < 10; i++)
            step(1, 95, 1, 0, 1, 1, $sformatf("band%0d", i));
        for (int i = 1; i <= 4; i++)
            step(1, 50, i != 4, 0, 1, 1, $sformatf("rel%0d", i));
        // Holdoff: onsets ignored, busy for 16 cycles total
        for (int i = 1; i <= 16; i++)
            step(i <= 4, 200, 0, 0, i < 16, 1, $sformatf("hold%0d", i));
        for (int i = 1; i <= 4; i++)
            step(1, 200, i == 4, i == 4, 1, (i == 4) ? 16'd2 : 16'd1, $sformatf("re_onset%0d", i));
        step(0, 0, 1, 0, 1, 2, "re_onset_end");

        // Negative sample clamps to 0 and counts as below 90
        for (int i = 1; i <= 4; i++)
            step(1, -300, i != 4, 0, 1, 2, $sformatf("neg_rel%0d", i));
        for (int i = 1; i <= 16; i++)
            step(0, 0, 0, 0, i < 16, 2, $sformatf("hold2_%0d", i));

        // Broken run restarts confirmation
        step(1, 150, 0, 0, 1, 2, "brk1");
        step(1, 150, 0, 0, 1, 2, "brk2");
        step(1, 150, 0, 0, 1, 2, "brk3");
        step(1, 80,  0, 0, 0, 2, "brk_low");
        step(1, 150, 0, 0, 1, 2, "brk5");
        step(1, 150, 0, 0, 1, 2, "brk6");
        step(1, 150, 0, 0, 1, 2, "brk7");
        step(1, 150, 1, 1, 1, 3, "brk8");

        // Drop to IDLE and back to MONITOR
        en = 1'b0;
        step(0, 0, 0, 0, 0, 3, "en_off1");
        en = 1'b1;
        step(0, 0, 0, 0, 0, 3, "en_on1");

        // Valid only every third cycle; gaps do not break the run
        for (int r = 1; r <= 4; r++) begin
            step(0, 0, 0, 0, r > 1, 3, $sformatf("gap%0d_a", r));
            step(0, 0, 0, 0, r > 1, 3, $sformatf("gap%0d_b", r));
            step(1, 150, r == 4, r == 4, 1, (r == 4) ? 16'd4 : 16'd3, $sformatf("gap%0d_v", r));
        end
        step(0, 0, 1, 0, 1, 4, "gap_end");

        // Release level clamps to 0: negative samples never release
        thresh = 33'sd5;
        for (int i = 0; i < 6; i++)
            step(1, -300, 1, 0, 1, 4, $sformatf("norel%0d", i));

        // Abort mid-ALARM: event count retained
        en = 1'b0;
        step(1, 150, 0, 0, 0, 4, "abort");
        en = 1'b1; thresh = 33'sd100;
        step(0, 0, 0, 0, 0, 4, "abort_mon");
        step(1, 150, 0, 0, 1, 4, "pre_rst1");
        step(1, 150, 0, 0, 1, 4, "pre_rst2");

        // Reset mid-CONFIRM clears the count and the run
        rst = 1'b1;
        step(1, 150, 0, 0, 0, 0, "mid_rst");
        rst = 1'b0;
        step(1, 150, 0, 0, 0, 0, "mid_rst_idle");
        for (int i = 1; i <= 4; i++)
            step(1, 150, i == 4, i == 4, 1, (i == 4) ? 16'd1 : 16'd0, $sformatf("post_rst_on%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
